// File: rtl/stack_ctrl_pkg.sv
// Shared state encoding and control-word table for the interrupt stack sequencer.
// Purely combinational decode; no latency. No flow control.
// Each state maps to one strobe word; MW is active-low so idle has mw=1.
package stack_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        P_A1, P_W1, P_D1, P_A2, P_W2, P_D2,
        R_I1, R_R1, R_L1, R_I2, R_R2, R_L2,
        DONE
    } state_t;

    typedef struct packed {
        logic enspa;
        logic enfld;
        logic endes;
        logic mw;
        logic mr;
        logic decsp;
        logic incsp;
        logic ldpc;
        logic ldflg;
        logic lreset;
        logic lint;
        logic busy;
        logic done;
    } ctrl_t;

    // Push stores flags then PC; pop restores PC then flags, mirroring the frame.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c      = '0;
        c.mw   = 1'b1;
        c.busy = (s != IDLE);
        case (s)
            P_A1: begin c.enspa = 1'b1; c.enfld = 1'b1; end
            P_W1: begin c.enspa = 1'b1; c.enfld = 1'b1; c.mw = 1'b0; end
            P_D1: c.decsp = 1'b1;
            P_A2: begin c.enspa = 1'b1; c.endes = 1'b1; end
            P_W2: begin c.enspa = 1'b1; c.endes = 1'b1; c.mw = 1'b0; end
            P_D2: begin c.decsp = 1'b1; c.lreset = 1'b1; c.lint = 1'b1; end
            R_I1: c.incsp = 1'b1;
            R_R1: begin c.enspa = 1'b1; c.mr = 1'b1; end
            R_L1: begin c.enspa = 1'b1; c.mr = 1'b1; c.ldpc = 1'b1; end
            R_I2: c.incsp = 1'b1;
            R_R2: begin c.enspa = 1'b1; c.mr = 1'b1; end
            R_L2: begin c.enspa = 1'b1; c.mr = 1'b1; c.ldflg = 1'b1; end
            DONE: c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stack_seq_ctrl.sv
// Interrupt entry/return stack sequencer: pushes flags+PC or pops PC+flags via strobes.
// Latency: request sampled in IDLE -> done 7 cycles later; outputs registered.
// No backpressure: a started sequence always completes; requests only sampled in IDLE.
// Optional STACK_GUARD_EN: refuse push/pop that would cross the stack bounds (stk_fault pulse).
module stack_seq_ctrl #(
    parameter int SP_W   = 8,
    parameter int SP_MIN = 0,
    parameter int SP_MAX = 2**SP_W-1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            int_req,
    input  logic            iret_req,
    input  logic [SP_W-1:0] sp,
    output logic            ENSPA,
    output logic            ENFLD,
    output logic            ENDES,
    output logic            MW,
    output logic            MR,
    output logic            DECSP,
    output logic            INCSP,
    output logic            LDPC,
    output logic            LDFLG,
    output logic            LRESET,
    output logic            LINT,
    output logic            busy,
    output logic            done,
    output logic            stk_fault
);
    import stack_ctrl_pkg::*;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   stk_fault_q;
    logic   guard_trip;

`ifdef STACK_GUARD_EN
    // A push needs two free slots below SP, a pop two filled slots above it.
    logic push_low;
    logic pop_high;
    assign push_low   = int'(sp) < SP_MIN + 2;
    assign pop_high   = int'(sp) > SP_MAX - 2;
    assign guard_trip = (state == IDLE) && (int_req ? push_low : (iret_req && pop_high));
`else
    logic unused_cfg;
    assign unused_cfg = (^sp) ^ (SP_MIN > SP_MAX);
    assign guard_trip = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (int_req)       state_nxt = P_A1;
                else if (iret_req) state_nxt = R_I1;
            end
            P_A1: state_nxt = P_W1;
            P_W1: state_nxt = P_D1;
            P_D1: state_nxt = P_A2;
            P_A2: state_nxt = P_W2;
            P_W2: state_nxt = P_D2;
            P_D2: state_nxt = DONE;
            R_I1: state_nxt = R_R1;
            R_R1: state_nxt = R_L1;
            R_L1: state_nxt = R_I2;
            R_I2: state_nxt = R_R2;
            R_R2: state_nxt = R_L2;
            R_L2: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (guard_trip) state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            ctrl        <= ctrl_of(IDLE);
            stk_fault_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            ctrl        <= ctrl_of(state_nxt);
            stk_fault_q <= guard_trip;
        end
    end

    assign ENSPA     = ctrl.enspa;
    assign ENFLD     = ctrl.enfld;
    assign ENDES     = ctrl.endes;
    assign MW        = ctrl.mw;
    assign MR        = ctrl.mr;
    assign DECSP     = ctrl.decsp;
    assign INCSP     = ctrl.incsp;
    assign LDPC      = ctrl.ldpc;
    assign LDFLG     = ctrl.ldflg;
    assign LRESET    = ctrl.lreset;
    assign LINT      = ctrl.lint;
    assign busy      = ctrl.busy;
    assign done      = ctrl.done;
    assign stk_fault = stk_fault_q;

endmodule
